// File: rtl/afe_config_tx_pkg.sv
// Shared definitions for the AFE configuration transmitter: frame layout,
// FSM state encoding and the frame builder.
package afe_pkg;

    localparam int FRAME_BITS = 20;
    localparam int SET_BITS   = 17;
    localparam logic [1:0] SYNC = 2'b10;

    localparam int RED_LSB = 17;
    localparam int IR_LSB  = 16;
    localparam int DRV_LSB = 12;
    localparam int DC_LSB  = 5;
    localparam int PGA_LSB = 1;
    localparam int PAR_LSB = 0;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Parity bit makes the whole 20-bit frame even.
    function automatic frame_t build_frame(input logic       red,
                                           input logic       ir,
                                           input logic [3:0] drv,
                                           input logic [6:0] dc,
                                           input logic [3:0] pga);
        frame_t f;
        f                     = '0;
        f[FRAME_BITS-1 -: 2]  = SYNC;
        f[RED_LSB]            = red;
        f[IR_LSB]             = ir;
        f[DRV_LSB +: 4]       = drv;
        f[DC_LSB +: 7]        = dc;
        f[PGA_LSB +: 4]       = pga;
        f[PAR_LSB]            = ^f[FRAME_BITS-1:1];
        return f;
    endfunction

endpackage

// File: rtl/afe_config_tx_if.sv
// 3-wire AFE configuration bus. The transmitter drives it through the master
// modport; an AFE (or its model) observes it through the slave modport.
interface afe_config_tx_if;

    logic SCLK;
    logic SDATA;
    logic CS_n;

    modport master (output SCLK, output SDATA, output CS_n);
    modport slave  (input  SCLK, input  SDATA, input  CS_n);

endinterface

// File: rtl/afe_config_tx_sclk_tick.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while run is high and
// pulses tick on the terminal count; held at zero while run is low.
module afe_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        tick  = run && (cnt_q == 8'(CLK_DIV - 1));
        cnt_d = cnt_q + 8'd1;
        if (!run || tick) cnt_d = '0;
    end

endmodule

// File: rtl/afe_config_tx.sv
// Sends the current LED / DC-comp / PGA settings to the AFE as a 20-bit frame
// whenever they change, after reset, or on force_send.
//
//   state | meaning
//   IDLE  | waiting for a change; captures the frame and drops CS_n on exit
//   LOAD  | one half-period of data setup before the first SCLK rise
//   SHIFT | 20 SCLK high/low pairs; final low half-period is the data hold
//   LATCH | CS_n high (AFE latches), 2 half-periods of inter-frame gap
module afe_config_tx import afe_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic [3:0]             LED_DRIVE,
    input  logic [6:0]             DC_Comp,
    input  logic [3:0]             PGA_Gain,
    input  logic                   LED_RED,
    input  logic                   LED_IR,
    input  logic                   force_send,
    afe_config_tx_if.master        afe_bus,
    output logic                   busy,
    output logic                   tx_done
);

    state_t               state_q, state_d;
    logic [SET_BITS-1:0]  snap_q, snap_d;
    logic                 snap_vld_q, snap_vld_d;
    logic [SET_BITS-1:0]  last_sent_q, last_sent_d;
    logic [SET_BITS-1:0]  sent_q, sent_d;
    logic                 pending_q, pending_d;
    frame_t               sr_q, sr_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 done_q, done_d;
    logic                 last_half_q, last_half_d;
    logic                 change;
    logic                 run;
    logic                 tick;

    assign run = (state_q != IDLE);

    afe_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK   (CLK),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            snap_vld_q  <= 1'b0;
            last_sent_q <= '0;
            sent_q      <= '0;
            pending_q   <= 1'b1;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
            last_half_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            snap_vld_q  <= snap_vld_d;
            last_sent_q <= last_sent_d;
            sent_q      <= sent_d;
            pending_q   <= pending_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            done_q      <= done_d;
            last_half_q <= last_half_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain};
        snap_vld_d  = 1'b1;
        last_sent_d = last_sent_q;
        sent_d      = sent_q;
        pending_d   = pending_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        done_d      = 1'b0;
        last_half_d = last_half_q;
        // snap is not meaningful until it has been loaded once after reset
        change = snap_vld_q && ((snap_q != last_sent_q) || pending_q || force_send);

        case (state_q)
            IDLE: begin
                if (change) begin
                    state_d     = LOAD;
                    sent_d      = snap_q;
                    sr_d        = build_frame(snap_q[16], snap_q[15], snap_q[14:11],
                                              snap_q[10:4], snap_q[3:0]);
                    pending_d   = 1'b0;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    bit_cnt_d   = 5'd19;
                    last_half_d = 1'b0;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != 5'd0) begin
                            sr_d      = {sr_q[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 5'd1;
                        end else begin
                            last_half_d = 1'b1;
                        end
                    end else if (last_half_q) begin
                        state_d     = LATCH;
                        cs_n_d      = 1'b1;
                        done_d      = 1'b1;
                        last_sent_d = sent_q;
                        last_half_d = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (last_half_q) begin
                        state_d     = IDLE;
                        last_half_d = 1'b0;
                    end else begin
                        last_half_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests during a frame never disturb it; they queue one follow-up frame.
        if (state_q != IDLE && (force_send || snap_q != sent_q)) pending_d = 1'b1;
    end

    always_comb begin
        afe_bus.SCLK  = sclk_q;
        afe_bus.SDATA = sr_q[FRAME_BITS-1];
        afe_bus.CS_n  = cs_n_q;
        busy          = (state_q != IDLE);
        tx_done       = done_q;
    end

endmodule
